// File: rtl/paquete_nucleo.sv
// Shared definitions for the RV32I core front end: fetch-stage states, the NOP
// word and the major opcodes used by the decoder and the sign-extension block.
package paquete_nucleo;

    typedef enum logic [1:0] {
        S_ARRANQUE = 2'd0,
        S_PEDIR    = 2'd1,
        S_ENTREGA  = 2'd2,
        S_ERROR    = 2'd3
    } estado_t;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [6:0] opcode_de(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/calculo_pc.sv
// Combinational next-PC: sequential step or PC-relative target from a
// half-word-scaled immediate, plus a flag for targets that are not word aligned.
module calculo_pc
    import paquete_nucleo::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inmediato,
    input  logic        salto,
    output logic [31:0] siguiente_pc,
    output logic        desalineado
);

    logic [31:0] destino;

    assign destino      = pc + (inmediato << 1);
    assign siguiente_pc = salto ? destino : pc + 32'd4;
    assign desalineado  = salto & destino[1];

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: one outstanding req/ack fetch, valid/ready delivery,
// branch redirect. Optional DESALINEO_CHECK_EN traps misaligned branch targets.
module etapa_busqueda
    import paquete_nucleo::*;
#(
    parameter logic [31:0] PC_INICIO = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instruccion_o,
    output logic [31:0] pc_o,
    output logic        valido_o,
    input  logic        listo_i,
    input  logic        salto_i,
    input  logic [31:0] inmediato_i,
    output logic        error_o
`ifdef DESALINEO_CHECK_EN
    ,
    output logic        desalineo_o
`endif
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    estado_t          estado;
    logic [31:0]      pc;
    logic [CNT_W-1:0] cuenta;
    logic [31:0]      siguiente_pc;
    logic             desalineado;

    calculo_pc u_calculo_pc (
        .pc           (pc),
        .inmediato    (inmediato_i),
        .salto        (salto_i),
        .siguiente_pc (siguiente_pc),
        .desalineado  (desalineado)
    );

`ifndef DESALINEO_CHECK_EN
    logic unused_desalineado;
    assign unused_desalineado = desalineado;
`endif

    assign pc_o        = pc;
    assign imem_addr_o = pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            estado        <= S_ARRANQUE;
            pc            <= PC_INICIO;
            instruccion_o <= INSTR_NOP;
            valido_o      <= 1'b0;
            imem_req_o    <= 1'b0;
            error_o       <= 1'b0;
            cuenta        <= '0;
`ifdef DESALINEO_CHECK_EN
            desalineo_o   <= 1'b0;
`endif
        end else begin
            case (estado)
                S_ARRANQUE: begin
                    estado     <= S_PEDIR;
                    imem_req_o <= 1'b1;
                    cuenta     <= '0;
                end
                S_PEDIR: begin
                    // An ack on the last allowed cycle still beats the timeout.
                    if (imem_ack_i) begin
                        instruccion_o <= imem_data_i;
                        cuenta        <= '0;
                        imem_req_o    <= 1'b0;
                        valido_o      <= 1'b1;
                        estado        <= S_ENTREGA;
                    end else if (cuenta == CNT_MAX) begin
                        error_o    <= 1'b1;
                        imem_req_o <= 1'b0;
                        estado     <= S_ERROR;
                    end else begin
                        cuenta <= cuenta + CNT_W'(1);
                    end
                end
                S_ENTREGA: begin
                    if (listo_i) begin
                        valido_o <= 1'b0;
`ifdef DESALINEO_CHECK_EN
                        if (desalineado) begin
                            desalineo_o <= 1'b1;
                            estado      <= S_ERROR;
                        end else begin
                            pc         <= siguiente_pc;
                            imem_req_o <= 1'b1;
                            estado     <= S_PEDIR;
                        end
`else
                        pc         <= siguiente_pc;
                        imem_req_o <= 1'b1;
                        estado     <= S_PEDIR;
`endif
                    end
                end
                S_ERROR: begin
                    imem_req_o <= 1'b0;
                    valido_o   <= 1'b0;
                end
                default: estado <= S_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_etapa_busqueda.sv
// Self-checking bench for etapa_busqueda: directed fetch/branch/timeout/reset
// steps plus a randomized run against a PC/memory reference model.
module tb_etapa_busqueda;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valido;
    logic        listo;
    logic        salto;
    logic [31:0] inmediato;
    logic        error;
`ifdef DESALINEO_CHECK_EN
    logic        desalineo;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] exp_pc;

    etapa_busqueda #(.PC_INICIO(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .instruccion_o (instr),
        .pc_o          (pc),
        .valido_o      (valido),
        .listo_i       (listo),
        .salto_i       (salto),
        .inmediato_i   (inmediato),
        .error_o       (error)
`ifdef DESALINEO_CHECK_EN
        ,
        .desalineo_o   (desalineo)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Memory contents as a pure function of the address; word 0 is addi x1,x0,5.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int budget, output int seen);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk1("req_seen", imem_req, 1'b1);
        seen = cyc;
    endtask

    // Called at a negedge with a request pending; acks after d further cycles.
    task automatic fetch(input int d);
        chk("fetch_addr", imem_addr, exp_pc);
        chk1("valid_low_in_req", valido, 1'b0);
        repeat (d) @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = mem_word(exp_pc);
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = $urandom;
        chk1("valido_up", valido, 1'b1);
        chk1("req_down", imem_req, 1'b0);
        chk("instr", instr, mem_word(exp_pc));
        chk("pc", pc, exp_pc);
    endtask

    // Holds off b cycles with noise on ignored inputs, then transfers.
    task automatic deliver(input int b, input logic br, input logic [31:0] imm);
        logic [31:0] held;
        held = instr;
        repeat (b) begin
            listo     = 1'b0;
            salto     = 1'($urandom);
            inmediato = $urandom;
            imem_ack  = 1'($urandom);
            imem_data = $urandom;
            @(negedge clk);
            chk1("hold_valid", valido, 1'b1);
            chk("hold_instr", instr, held);
            chk("hold_pc", pc, exp_pc);
            chk1("hold_req", imem_req, 1'b0);
        end
        imem_ack  = 1'b0;
        listo     = 1'b1;
        salto     = br;
        inmediato = imm;
        @(negedge clk);
        listo     = 1'b0;
        salto     = 1'b0;
        inmediato = 32'h0;
        exp_pc    = br ? exp_pc + imm * 32'd2 : exp_pc + 32'd4;
        chk1("valid_drop", valido, 1'b0);
    endtask

    initial begin
        int c;
        int cprev;
        int off;
        rst = 1'b1; imem_ack = 1'b0; imem_data = 32'h0;
        listo = 1'b0; salto = 1'b0; inmediato = 32'h0;
        exp_pc = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk1("rst_valid", valido, 1'b0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_error", error, 1'b0);
`ifdef DESALINEO_CHECK_EN
        chk1("rst_desalineo", desalineo, 1'b0);
`endif
        rst = 1'b0;

        // Sequential fetches, 1-cycle ack, consumer always ready
        cprev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_req(6, c);
            chk("seq_addr", imem_addr, 32'(4 * i));
            if (i > 0) chk("period", 32'(c - cprev), 32'd3);
            cprev = c;
            fetch(1);
            deliver(0, 1'b0, 32'h0);
        end

        // Backpressure
        wait_req(6, c);
        fetch(1);
        deliver(5, 1'b0, 32'h0);

        // Branch directed: to 0x100, back 16 bytes, forward 32 bytes
        wait_req(6, c);
        fetch(0);
        deliver(0, 1'b1, (32'h100 - exp_pc) >> 1);
        wait_req(6, c);
        chk("at_100", imem_addr, 32'h100);
        fetch(1);
        deliver(0, 1'b1, 32'hFFFF_FFF8);
        wait_req(6, c);
        chk("br_neg", imem_addr, 32'h0F0);
        fetch(1);
        deliver(0, 1'b1, 32'h8);
        wait_req(6, c);
        fetch(1);
        deliver(0, 1'b1, 32'h10);
        wait_req(6, c);
        chk("br_pos", imem_addr, 32'h120);

        // Wrap past the top of the address space
        fetch(1);
        deliver(0, 1'b1, (32'hFFFF_FFFC - exp_pc) >> 1);
        wait_req(6, c);
        chk("at_top", imem_addr, 32'hFFFF_FFFC);
        fetch(2);
        deliver(1, 1'b0, 32'h0);
        wait_req(6, c);
        chk("wrap", imem_addr, 32'h0);

        // Randomized fetch/deliver run
        for (int i = 0; i < 25; i++) begin
            fetch(int'($urandom_range(0, 3)));
            off = int'($urandom_range(0, 64)) - 32;
            deliver(int'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3), 32'(2 * off));
            wait_req(6, c);
        end

        // Timeout: no ack for 16 request cycles
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            chk1("to_req_hold", imem_req, 1'b1);
            chk1("to_no_err_yet", error, 1'b0);
        end
        @(negedge clk);
        chk1("to_error", error, 1'b1);
        chk1("to_req_drop", imem_req, 1'b0);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        chk1("err_ack_ignored", valido, 1'b0);
        chk1("err_sticky", error, 1'b1);
        chk1("err_req_low", imem_req, 1'b0);

        // Ack on the 16th request cycle wins over the timeout
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_clears_err", error, 1'b0);
        rst = 1'b0;
        exp_pc = 32'h0;
        wait_req(6, c);
        fetch(15);
        chk1("edge_no_err", error, 1'b0);
        deliver(0, 1'b0, 32'h0);

        // Reset mid-request; ack during and right after reset is ignored
        wait_req(6, c);
        rst = 1'b1;
        #1;
        chk1("async_req_drop", imem_req, 1'b0);
        chk("async_pc", pc, 32'h0);
        imem_ack = 1'b1; imem_data = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk1("late_ack_valid", valido, 1'b0);
        chk("late_ack_instr", instr, 32'h0000_0013);
        exp_pc = 32'h0;
        wait_req(6, c);
        fetch(1);

`ifdef DESALINEO_CHECK_EN
        listo = 1'b1; salto = 1'b1; inmediato = 32'h1;
        @(negedge clk);
        listo = 1'b0; salto = 1'b0; inmediato = 32'h0;
        chk1("mis_flag", desalineo, 1'b1);
        chk("mis_pc", pc, 32'h0);
        chk1("mis_valid", valido, 1'b0);
        chk1("mis_error", error, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk1("mis_req_low", imem_req, 1'b0);
        end
`else
        deliver(0, 1'b1, 32'h1);
        wait_req(6, c);
        chk("unchecked_target", imem_addr, 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/etapa_busqueda.md
Name: etapa_busqueda

Overview:
- Instruction-fetch stage of the RV32I single-cycle core. Sits directly upstream of the immediate sign-extension block and the decoder.
- Holds the PC and fetches one 32-bit word per request over a req/ack instruction-memory port.
- Presents the instruction with a valid/ready handshake.
- Redirects the PC using the sign-extended immediate returned for B/J instructions.

Parameters:
- PC_INICIO, 32'h0000_0000: PC value loaded on reset.
- TIMEOUT, 16: max cycles from imem_req_o assertion to imem_ack_i before error_o sets; legal range 2..65535.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_i  input  1  asynchronous reset, active-high
- imem_req_o  output  1  fetch request to instruction memory
- imem_addr_o  output  32  fetch address; equals pc_o
- imem_ack_i  input  1  memory returns imem_data_i this cycle
- imem_data_i  input  32  fetched instruction word
- instruccion_o  output  32  held instruction to decoder / sign-extension block
- pc_o  output  32  PC of instruccion_o
- valido_o  output  1  instruccion_o/pc_o valid
- listo_i  input  1  consumer accepts the instruction this cycle
- salto_i  input  1  taken branch or JAL for the instruction being accepted
- inmediato_i  input  32  sign-extended offset from the sign-extension block, in half-word units (bit 0 not included)
- error_o  output  1  sticky: memory ack timeout

Behaviour:
- Reset (rst_i high, asynchronous):
  - state=S_ARRANQUE, pc=PC_INICIO.
  - instruccion_o=32'h0000_0013 (NOP).
  - valido_o=0, imem_req_o=0, error_o=0, timeout counter=0.
- States:
  - S_ARRANQUE: one idle cycle after reset release, then goes to S_PEDIR.
  - S_PEDIR:
    - imem_req_o=1, imem_addr_o=pc; counter increments each cycle.
    - On imem_ack_i: latch imem_data_i into instruccion_o, clear counter, go to S_ENTREGA. valido_o rises the cycle after the ack.
    - If counter reaches TIMEOUT-1 without ack: set error_o, go to S_ERROR.
  - S_ENTREGA:
    - valido_o=1, imem_req_o=0; outputs held stable while listo_i=0.
    - On listo_i=1 (transfer): pc <= salto_i ? pc + (inmediato_i << 1) : pc + 4; go to S_PEDIR.
  - S_ERROR: imem_req_o=0, valido_o=0. Exit only via reset.
- Latency: minimum 3 cycles per instruction (request, ack-latch, deliver) with a 1-cycle-ack memory. No prefetch; at most one outstanding request.
- Signal qualification:
  - salto_i and inmediato_i are sampled only on the transfer cycle and ignored otherwise.
  - imem_ack_i outside S_PEDIR is ignored.
- Arithmetic: 32-bit modular; target wraps past 32'hFFFF_FFFC with no flag.
- Ack on the same cycle the counter hits TIMEOUT-1: the ack wins, no error.
- Reset mid-request: request drops immediately (asynchronous); any late ack is ignored.

Optional Feature:
- DESALINEO_CHECK_EN defined:
  - On a transfer with salto_i=1 where the computed target bit 1 = 1, the PC is not updated and the block enters S_ERROR.
  - A separate sticky output desalineo_o (1 bit, reset 0) sets.
- Not defined: port absent; the target is loaded unchecked.

Decomposition:
- Package paquete_nucleo: state encoding (S_ARRANQUE, S_PEDIR, S_ENTREGA, S_ERROR), NOP constant 32'h0000_0013, opcode constants shared with the decoder and sign-extension block.
- One sub-module, calculo_pc: combinational next-PC adder (pc, inmediato_i, salto_i -> siguiente_pc, desalineado).

Test Plan:
- Reset release, memory acks after 1 cycle with 32'h00500093 -> imem_addr_o=0; valido_o=1 two cycles after the ack cycle's request; pc_o=0.
- Sequential accept, listo_i tied 1 -> fetch addresses 0,4,8,12; one instruction every 3 cycles.
- Backpressure: listo_i=0 for 5 cycles -> instruccion_o/pc_o stable, imem_req_o=0, no new fetch.
- Branch: pc_o=0x100, salto_i=1, inmediato_i=32'hFFFF_FFF8 -> next imem_addr_o=0x0F0; separately inmediato_i=0x10 -> 0x120.
- Timeout, TIMEOUT=16, no ack -> error_o=1 on the 16th request cycle, then req=0; ack arriving on cycle 16 instead -> no error.
- DESALINEO_CHECK_EN: pc_o=0, inmediato_i=1 -> desalineo_o=1, PC stays 0, state S_ERROR.
